// File: rtl/ce_mon_pkg.sv
// Shared types and constants for the clock-enable strobe monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   CNT_W, ERR_W   widths of the interval counter and the error counter
//   mon_state_e    SEARCH (no reference strobe), TRACK (measuring), LOCKED
//   nom_cycles()   nominal strobe period in clk cycles from the two periods in ns
package ce_mon_pkg;

   localparam int CNT_W = 19;
   localparam int ERR_W = 8;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } mon_state_e;

   // Nominal number of clk cycles between strobes.
   function automatic int nom_cycles(input int tst_ns, input int tclk_ns);
      return tst_ns / tclk_ns;
   endfunction

endpackage

// File: rtl/st_interval_cnt.sv
// Interval counter: counts clk cycles since the last strobe, restarting at 1 on a strobe.
// Latency: cnt reflects the strobe one clk after it is sampled.
// Backpressure: none; free-running observer.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset, clears the count to 0
//   ce_st  in   strobe under test
//   cnt    out  CNT_W-bit interval count, saturates at all-ones
module st_interval_cnt
   import ce_mon_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_st,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Loading 1 (not 0) on the strobe makes the value seen on the next strobe
   // cycle equal to the number of cycles between the two strobes.
   always_comb begin
      cnt_d = cnt_q;
      if (ce_st) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/ce_st_monitor.sv
// Receiving-end checker for the periodic ce_st strobe: measures intervals, tracks lock, flags early/late.
// Latency: every output is registered, one clk after the deciding edge.
// Backpressure: none; passive observer, never stalls the strobe source.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   ce_st       in   strobe under test, one clk wide, synchronous to clk
//   lock        out  level, strobe periodic and within window
//   period      out  last measured interval in cycles
//   period_vld  out  one-cycle pulse, period updated
//   err_early   out  one-cycle pulse, interval below NOM-TOL
//   err_late    out  one-cycle pulse, interval reached NOM+TOL+1 (late or missing strobe)
//   err_cnt     out  saturating count of early and late events
module ce_st_monitor
   import ce_mon_pkg::*;
#(
   parameter int TCLK   = 20,
   parameter int TST    = 100000,
   parameter int TOL    = 2,
   parameter int LOCK_N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_st,
   output logic             lock,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             err_early,
   output logic             err_late,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int NOM     = nom_cycles(TST, TCLK);
   localparam int WIN_LO  = NOM - TOL;
   localparam int LATE_AT = NOM + TOL + 1;
   localparam int GOOD_W  = $clog2(LOCK_N + 1);

   localparam logic [CNT_W-1:0]  WIN_LO_C  = CNT_W'(WIN_LO);
   localparam logic [CNT_W-1:0]  LATE_AT_C = CNT_W'(LATE_AT);
   localparam logic [GOOD_W-1:0] LOCK_N_C  = GOOD_W'(LOCK_N);

   // A window starting below 2 could not tell a stuck-high strobe from a good
   // one, and a late threshold outside the counter range would never fire.
   if (WIN_LO < 2) begin : g_bad_window
      $fatal(1, "ce_st_monitor: NOM-TOL must be at least 2");
   end
   if (LATE_AT >= (1 << CNT_W)) begin : g_bad_late
      $fatal(1, "ce_st_monitor: NOM+TOL+1 exceeds the interval counter range");
   end
   if (LOCK_N < 1) begin : g_bad_lock
      $fatal(1, "ce_st_monitor: LOCK_N must be at least 1");
   end

   logic [CNT_W-1:0] cnt;

   st_interval_cnt u_interval_cnt (
      .clk   (clk),
      .rst   (rst),
      .ce_st (ce_st),
      .cnt   (cnt)
   );

   mon_state_e        state_q, state_d;
   logic [GOOD_W-1:0] good_q, good_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              period_vld_q, period_vld_d;
   logic              err_early_q, err_early_d;
   logic              err_late_q, err_late_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic              lock_q, lock_d;

   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      period_d     = period_q;
      period_vld_d = 1'b0;
      err_early_d  = 1'b0;
      err_late_d   = 1'b0;

      unique case (state_q)
         SEARCH: begin
            // First strobe only sets the reference; there is no interval yet.
            if (ce_st) begin
               state_d = TRACK;
               good_d  = '0;
            end
         end

         TRACK, LOCKED: begin
            if (ce_st) begin
               period_d     = cnt;
               period_vld_d = 1'b1;
               if (cnt >= LATE_AT_C) begin
                  // A strobe on the late threshold is reported only as late,
                  // but still serves as the new reference.
                  err_late_d = 1'b1;
                  good_d     = '0;
                  state_d    = TRACK;
               end else if (cnt < WIN_LO_C) begin
                  err_early_d = 1'b1;
                  good_d      = '0;
                  state_d     = TRACK;
               end else begin
                  if (good_q != LOCK_N_C) begin
                     good_d = good_q + GOOD_W'(1);
                  end
                  if (good_d == LOCK_N_C) begin
                     state_d = LOCKED;
                  end
               end
            end else if (cnt == LATE_AT_C) begin
               // Missing strobe: drop the reference. The counter keeps running
               // and saturates, so no further late pulses occur in SEARCH.
               err_late_d = 1'b1;
               good_d     = '0;
               state_d    = SEARCH;
            end
         end

         default: begin
            state_d = SEARCH;
            good_d  = '0;
         end
      endcase
   end

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((err_early_d || err_late_d) && (err_cnt_q != {ERR_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
      lock_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SEARCH;
         good_q       <= '0;
         period_q     <= '0;
         period_vld_q <= 1'b0;
         err_early_q  <= 1'b0;
         err_late_q   <= 1'b0;
         err_cnt_q    <= '0;
         lock_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         good_q       <= good_d;
         period_q     <= period_d;
         period_vld_q <= period_vld_d;
         err_early_q  <= err_early_d;
         err_late_q   <= err_late_d;
         err_cnt_q    <= err_cnt_d;
         lock_q       <= lock_d;
      end
   end

   assign lock       = lock_q;
   assign period     = period_q;
   assign period_vld = period_vld_q;
   assign err_early  = err_early_q;
   assign err_late   = err_late_q;
   assign err_cnt    = err_cnt_q;

endmodule
